// File: rtl/debug_controller_pkg.sv
// Types for the host-side debug controller.
// Opcodes, FSM states, response bundle and the injected filler instruction.
package dbg_types;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_HALT   = 3'd1,
    OP_RESUME = 3'd2,
    OP_RDREG  = 3'd3,
    OP_WRREG  = 3'd4,
    OP_EXEC   = 3'd5,
    OP_INIT   = 3'd6,
    OP_RSVD   = 3'd7
  } dbg_op_e;

  typedef enum logic [2:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED,
    S_RD,
    S_WR,
    S_EXEC,
    S_RSP
  } dbg_state_e;

  localparam logic [31:0] NOP_INS = 32'h0000_0013;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } dbg_rsp_t;

  localparam dbg_rsp_t RSP_OK  = '{err: 1'b0, data: 32'h0};
  localparam dbg_rsp_t RSP_ERR = '{err: 1'b1, data: 32'h0};

endpackage

// File: rtl/reg_pkg.sv
// Register-file transport types shared by the core and its debug port.
// reg_transport_t carries one register write (address + value).
package reg_pkg;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] value;
  } reg_transport_t;

endpackage

// File: rtl/debug_controller.sv
// Debug-port initiator: takes transport commands, drives core DBG_* signals.
// Ports: iCmd_* command handshake, oRsp_* response handshake, oDbg_*/iDbg_* core side.
module debug_controller
  import dbg_types::*;
  import reg_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES  = 5,
  parameter int unsigned EXEC_CYCLES   = 5,
  parameter bit          HALT_ON_RESET = 1'b0
) (
  input  logic           iClk,
  input  logic           nRst,
  input  logic           iCmd_valid,
  output logic           oCmd_ready,
  input  logic [2:0]     iCmd_op,
  input  logic [4:0]     iCmd_addr,
  input  logic [31:0]    iCmd_data,
  output logic           oRsp_valid,
  input  logic           iRsp_ready,
  output logic           oRsp_err,
  output logic [31:0]    oRsp_data,
  output logic           oHalted,
  output logic           oDbg_halt,
  output logic           oDbg_exec,
  output logic           oDbg_req_init,
  output logic           oDbg_regWrite,
  output logic [31:0]    oDbg_ins,
  output reg_transport_t oDbg_rd,
  output logic [4:0]     oDbg_rsAddr,
  input  logic [31:0]    iDbg_rsValue
);

  localparam int CW = 16;
  // Counters are loaded with N-1 so the exit edge is the N-th cycle.
  localparam logic [CW-1:0] DRAIN_LD = CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_CYCLES - 1);
  localparam dbg_state_e RST_ST = HALT_ON_RESET ? S_HALTED : S_RUN;

  dbg_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           halt_q, halt_d;
  logic           halted_q, halted_d;
  logic           exec_q, exec_d;
  logic           init_q, init_d;
  logic           wr_q, wr_d;
  logic [31:0]    ins_q, ins_d;
  reg_transport_t rd_q, rd_d;
  logic [4:0]     rsa_q, rsa_d;
  dbg_rsp_t       rsp_q, rsp_d;
  logic           rspv_q, rspv_d;

  dbg_op_e op;
  logic    accept;
  logic    running;

  assign op      = dbg_op_e'(iCmd_op);
  assign running = (state_q == S_RUN);
  assign accept  = iCmd_valid & oCmd_ready;

  assign oCmd_ready    = (state_q == S_RUN) | (state_q == S_HALTED);
  assign oRsp_valid    = rspv_q;
  assign oRsp_err      = rsp_q.err;
  assign oRsp_data     = rsp_q.data;
  assign oHalted       = halted_q;
  assign oDbg_halt     = halt_q;
  assign oDbg_exec     = exec_q;
  assign oDbg_req_init = init_q;
  assign oDbg_regWrite = wr_q;
  assign oDbg_ins      = ins_q;
  assign oDbg_rd       = rd_q;
  assign oDbg_rsAddr   = rsa_q;

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= RST_ST;
      cnt_q    <= '0;
      halt_q   <= HALT_ON_RESET;
      halted_q <= HALT_ON_RESET;
      exec_q   <= 1'b0;
      init_q   <= 1'b0;
      wr_q     <= 1'b0;
      ins_q    <= '0;
      rd_q     <= '0;
      rsa_q    <= '0;
      rsp_q    <= RSP_OK;
      rspv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halt_q   <= halt_d;
      halted_q <= halted_d;
      exec_q   <= exec_d;
      init_q   <= init_d;
      wr_q     <= wr_d;
      ins_q    <= ins_d;
      rd_q     <= rd_d;
      rsa_q    <= rsa_d;
      rsp_q    <= rsp_d;
      rspv_q   <= rspv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_RUN, S_HALTED: begin
        if (accept) begin
          state_d = S_RSP;
          unique case (op)
            OP_HALT: if (running) begin
              state_d = S_DRAIN;
              cnt_d   = DRAIN_LD;
            end
            OP_RDREG: if (!running) state_d = S_RD;
            OP_WRREG: if (!running) state_d = S_WR;
            OP_EXEC: if (!running) begin
              state_d = S_EXEC;
              cnt_d   = EXEC_LD;
            end
            default: state_d = S_RSP;
          endcase
        end
      end
      S_DRAIN, S_EXEC: begin
        if (cnt_q == '0) state_d = S_RSP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_RD, S_WR: state_d = S_RSP;
      S_RSP: begin
        if (iRsp_ready) state_d = halted_q ? S_HALTED : S_RUN;
      end
      default: state_d = RST_ST;
    endcase
  end

  always_comb begin
    halt_d   = halt_q;
    halted_d = halted_q;
    exec_d   = exec_q;
    init_d   = 1'b0;
    wr_d     = 1'b0;
    ins_d    = ins_q;
    rd_d     = rd_q;
    rsa_d    = rsa_q;
    rsp_d    = rsp_q;
    rspv_d   = rspv_q;
    unique case (state_q)
      S_RUN, S_HALTED: begin
        if (accept) begin
          rspv_d = 1'b1;
          rsp_d  = RSP_OK;
          unique case (op)
            OP_HALT: if (running) begin
              halt_d = 1'b1;
              rspv_d = 1'b0;
            end
            OP_RESUME: begin
              halt_d   = 1'b0;
              halted_d = 1'b0;
            end
            OP_RDREG: begin
              if (running) rsp_d = RSP_ERR;
              else begin
                rsa_d  = iCmd_addr;
                rspv_d = 1'b0;
              end
            end
            OP_WRREG: begin
              if (running) rsp_d = RSP_ERR;
              else begin
                wr_d   = 1'b1;
                rd_d   = '{addr: iCmd_addr, value: iCmd_data};
                rspv_d = 1'b0;
              end
            end
            OP_EXEC: begin
              if (running) rsp_d = RSP_ERR;
              else begin
                halt_d = 1'b0;
                exec_d = 1'b1;
                ins_d  = iCmd_data;
                rspv_d = 1'b0;
              end
            end
            OP_INIT: init_d = 1'b1;
            OP_RSVD: rsp_d  = RSP_ERR;
            default: rsp_d  = RSP_OK;
          endcase
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          halted_d = 1'b1;
          rspv_d   = 1'b1;
          rsp_d    = RSP_OK;
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          halt_d = 1'b1;
          exec_d = 1'b0;
          rspv_d = 1'b1;
          rsp_d  = RSP_OK;
        end else begin
          ins_d = NOP_INS;
        end
      end
      S_RD: begin
        rspv_d = 1'b1;
        rsp_d  = '{err: 1'b0, data: iDbg_rsValue};
      end
      S_WR: begin
        rspv_d = 1'b1;
        rsp_d  = RSP_OK;
      end
      S_RSP: begin
        if (iRsp_ready) begin
          rspv_d = 1'b0;
          rsp_d  = RSP_OK;
        end
      end
      default: rspv_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_debug_controller.sv
// Self-checking bench for debug_controller.
// Directed scenarios plus random commands against a command-level model.
module tb_debug_controller;
  import dbg_types::*;
  import reg_pkg::*;

  localparam int DRAIN = 5;
  localparam int EXECN = 5;

  logic           clk = 1'b0;
  logic           nRst = 1'b0;
  logic           iCmd_valid = 1'b0;
  logic           oCmd_ready;
  logic [2:0]     iCmd_op = '0;
  logic [4:0]     iCmd_addr = '0;
  logic [31:0]    iCmd_data = '0;
  logic           oRsp_valid;
  logic           iRsp_ready = 1'b0;
  logic           oRsp_err;
  logic [31:0]    oRsp_data;
  logic           oHalted;
  logic           oDbg_halt;
  logic           oDbg_exec;
  logic           oDbg_req_init;
  logic           oDbg_regWrite;
  logic [31:0]    oDbg_ins;
  reg_transport_t oDbg_rd;
  logic [4:0]     oDbg_rsAddr;
  logic [31:0]    iDbg_rsValue;

  int nvec = 0;
  int nfail = 0;

  // core register-file stand-in, written only through the debug port
  logic [31:0] rf [32] = '{default: 32'h0};
  // reference expectation of register contents
  logic [31:0] mrf [32] = '{default: 32'h0};
  bit m_halted = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (oDbg_regWrite && oDbg_rd.addr != 5'd0)
      rf[oDbg_rd.addr] <= oDbg_rd.value;

  assign iDbg_rsValue = (oDbg_rsAddr == 5'd0) ? 32'h0 : rf[oDbg_rsAddr];

  debug_controller #(
    .DRAIN_CYCLES (DRAIN),
    .EXEC_CYCLES  (EXECN),
    .HALT_ON_RESET(1'b0)
  ) dut (
    .iClk         (clk),
    .nRst         (nRst),
    .iCmd_valid   (iCmd_valid),
    .oCmd_ready   (oCmd_ready),
    .iCmd_op      (iCmd_op),
    .iCmd_addr    (iCmd_addr),
    .iCmd_data    (iCmd_data),
    .oRsp_valid   (oRsp_valid),
    .iRsp_ready   (iRsp_ready),
    .oRsp_err     (oRsp_err),
    .oRsp_data    (oRsp_data),
    .oHalted      (oHalted),
    .oDbg_halt    (oDbg_halt),
    .oDbg_exec    (oDbg_exec),
    .oDbg_req_init(oDbg_req_init),
    .oDbg_regWrite(oDbg_regWrite),
    .oDbg_ins     (oDbg_ins),
    .oDbg_rd      (oDbg_rd),
    .oDbg_rsAddr  (oDbg_rsAddr),
    .iDbg_rsValue (iDbg_rsValue)
  );

  // observations of the last command
  int             r_lat, r_wait;
  logic           r_err, r_halted, r_dbghalt;
  logic [31:0]    r_data;
  int             n_exec, n_wr, n_init, n_haltlow, n_nopins;
  int             n_unstable, n_rdy_hold;
  logic           halt_first;
  reg_transport_t rd_first;
  logic [31:0]    ins_first;
  logic           after_valid, after_ready;

  task automatic sample_core();
    if (r_lat == 1) begin
      halt_first = oDbg_halt;
      rd_first   = oDbg_rd;
      ins_first  = oDbg_ins;
    end else if (oDbg_exec && oDbg_ins == NOP_INS) begin
      n_nopins++;
    end
    if (oDbg_exec)     n_exec++;
    if (oDbg_regWrite) n_wr++;
    if (oDbg_req_init) n_init++;
    if (!oDbg_halt)    n_haltlow++;
  endtask

  // Issue one command, wait for its response, hold it `hold` cycles, take it.
  task automatic send(input logic [2:0] op, input logic [4:0] addr,
                      input logic [31:0] data, input int hold);
    logic [32:0] rsp0;
    n_exec = 0; n_wr = 0; n_init = 0; n_haltlow = 0; n_nopins = 0;
    n_unstable = 0; n_rdy_hold = 0; r_wait = 0;
    while (!oCmd_ready && r_wait < 50) begin
      @(posedge clk); #1;
      r_wait++;
    end
    iCmd_valid = 1'b1;
    iCmd_op    = op;
    iCmd_addr  = addr;
    iCmd_data  = data;
    @(posedge clk); #1;
    iCmd_valid = 1'b0;
    iCmd_op    = 3'($urandom);
    iCmd_addr  = 5'($urandom);
    iCmd_data  = $urandom;
    r_lat = 1;
    sample_core();
    while (!oRsp_valid && r_lat < 40) begin
      @(posedge clk); #1;
      r_lat++;
      sample_core();
    end
    if (!oRsp_valid) begin
      nvec++; nfail++;
      $display("FAIL rsp_timeout op=%0d got no response, required one", op);
    end
    r_err     = oRsp_err;
    r_data    = oRsp_data;
    r_halted  = oHalted;
    r_dbghalt = oDbg_halt;
    rsp0 = {oRsp_err, oRsp_data};
    repeat (hold) begin
      @(posedge clk); #1;
      if (!oRsp_valid || {oRsp_err, oRsp_data} != rsp0) n_unstable++;
      if (oCmd_ready) n_rdy_hold++;
    end
    iRsp_ready = 1'b1;
    @(posedge clk); #1;
    iRsp_ready = 1'b0;
    after_valid = oRsp_valid;
    after_ready = oCmd_ready;
  endtask

  task automatic test_reset();
    nvec++;
    if ({oCmd_ready, oRsp_valid, oRsp_err, oRsp_data} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      nfail++;
      $display("FAIL reset_rsp got rdy=%b v=%b e=%b d=%h required 1 0 0 0",
               oCmd_ready, oRsp_valid, oRsp_err, oRsp_data);
    end
    nvec++;
    if ({oDbg_halt, oHalted, oDbg_exec, oDbg_req_init, oDbg_regWrite} !== 5'b0 ||
        oDbg_ins !== 32'h0 || oDbg_rd !== '0 || oDbg_rsAddr !== 5'd0) begin
      nfail++;
      $display("FAIL reset_core got h=%b hd=%b x=%b i=%b w=%b ins=%h rd=%h rs=%0d required all 0",
               oDbg_halt, oHalted, oDbg_exec, oDbg_req_init, oDbg_regWrite,
               oDbg_ins, oDbg_rd, oDbg_rsAddr);
    end
  endtask

  task automatic test_halt();
    send(3'(OP_HALT), 5'd0, 32'h0, 0);
    m_halted = 1'b1;
    nvec++;
    if (halt_first !== 1'b1) begin
      nfail++; $display("FAIL halt_rise got %b required 1", halt_first);
    end
    nvec++;
    if (r_lat != DRAIN + 1) begin
      nfail++; $display("FAIL halt_lat got %0d required %0d", r_lat, DRAIN + 1);
    end
    nvec++;
    if (r_err !== 1'b0 || r_halted !== 1'b1) begin
      nfail++; $display("FAIL halt_rsp got err=%b halted=%b required 0 1", r_err, r_halted);
    end
  endtask

  task automatic test_wr_rd();
    send(3'(OP_WRREG), 5'd5, 32'hDEADBEEF, 0);
    mrf[5] = 32'hDEADBEEF;
    nvec++;
    if (n_wr != 1 || rd_first !== '{addr: 5'd5, value: 32'hDEADBEEF}) begin
      nfail++;
      $display("FAIL wr_pulse got n=%0d rd=%h required 1 %h", n_wr, rd_first,
               {5'd5, 32'hDEADBEEF});
    end
    nvec++;
    if (r_lat != 2 || r_err !== 1'b0) begin
      nfail++; $display("FAIL wr_lat got lat=%0d err=%b required 2 0", r_lat, r_err);
    end
    send(3'(OP_RDREG), 5'd5, 32'h0, 0);
    nvec++;
    if (r_data !== 32'hDEADBEEF || r_lat != 2 || r_err !== 1'b0) begin
      nfail++;
      $display("FAIL rd_data got d=%h lat=%0d e=%b required deadbeef 2 0",
               r_data, r_lat, r_err);
    end
  endtask

  task automatic test_exec();
    send(3'(OP_EXEC), 5'd0, 32'h00500093, 0);
    nvec++;
    if (ins_first !== 32'h00500093 || n_nopins != EXECN - 1) begin
      nfail++;
      $display("FAIL exec_ins got first=%h nops=%0d required 00500093 %0d",
               ins_first, n_nopins, EXECN - 1);
    end
    nvec++;
    if (n_haltlow != EXECN || n_exec != EXECN) begin
      nfail++;
      $display("FAIL exec_window got haltlow=%0d exec=%0d required %0d",
               n_haltlow, n_exec, EXECN);
    end
    nvec++;
    if (r_lat != EXECN + 1 || r_dbghalt !== 1'b1 || r_err !== 1'b0) begin
      nfail++;
      $display("FAIL exec_rsp got lat=%0d halt=%b err=%b required %0d 1 0",
               r_lat, r_dbghalt, r_err, EXECN + 1);
    end
  endtask

  task automatic test_errors();
    logic [4:0] rs0;
    send(3'(OP_RESUME), 5'd0, 32'h0, 0);
    m_halted = 1'b0;
    nvec++;
    if (r_halted !== 1'b0 || r_dbghalt !== 1'b0) begin
      nfail++; $display("FAIL resume got halted=%b halt=%b required 0 0", r_halted, r_dbghalt);
    end
    rs0 = oDbg_rsAddr;
    send(3'(OP_RDREG), 5'd3, 32'h0, 0);
    nvec++;
    if (r_err !== 1'b1 || r_data !== 32'h0 || r_lat != 1) begin
      nfail++;
      $display("FAIL rd_running got e=%b d=%h lat=%0d required 1 0 1", r_err, r_data, r_lat);
    end
    nvec++;
    if (oDbg_rsAddr !== rs0 || n_wr != 0 || n_exec != 0) begin
      nfail++;
      $display("FAIL rd_running_core got rs=%0d w=%0d x=%0d required %0d 0 0",
               oDbg_rsAddr, n_wr, n_exec, rs0);
    end
    send(3'd7, 5'd1, 32'h1234, 0);
    nvec++;
    if (r_err !== 1'b1 || r_lat != 1) begin
      nfail++; $display("FAIL reserved got e=%b lat=%0d required 1 1", r_err, r_lat);
    end
  endtask

  task automatic test_back_to_back();
    send(3'(OP_RESUME), 5'd0, 32'h0, 10);
    nvec++;
    if (n_unstable != 0 || n_rdy_hold != 0) begin
      nfail++;
      $display("FAIL hold got unstable=%0d ready_cycles=%0d required 0 0",
               n_unstable, n_rdy_hold);
    end
    nvec++;
    if (after_valid !== 1'b0 || after_ready !== 1'b1) begin
      nfail++;
      $display("FAIL release got v=%b rdy=%b required 0 1", after_valid, after_ready);
    end
    send(3'(OP_NOP), 5'd0, 32'h0, 0);
    nvec++;
    if (r_wait != 0 || r_lat != 1 || r_err !== 1'b0) begin
      nfail++;
      $display("FAIL next_cmd got wait=%0d lat=%0d e=%b required 0 1 0", r_wait, r_lat, r_err);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    iCmd_valid = 1'b1;
    iCmd_op    = 3'(OP_HALT);
    @(posedge clk); #1;
    iCmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    nRst = 1'b0;
    #1;
    nvec++;
    if ({oDbg_halt, oHalted, oRsp_valid, oCmd_ready} !== 4'b0001 ||
        oDbg_rd !== '0 || oDbg_rsAddr !== 5'd0 || oDbg_ins !== 32'h0) begin
      nfail++;
      $display("FAIL mid_reset got h=%b hd=%b v=%b rdy=%b required 0 0 0 1",
               oDbg_halt, oHalted, oRsp_valid, oCmd_ready);
    end
    #3;
    nRst = 1'b1;
    m_halted = 1'b0;
    for (int k = 0; k < 32; k++) mrf[k] = rf[k];
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (oRsp_valid || oDbg_halt) seen++;
    end
    nvec++;
    if (seen != 0) begin
      nfail++; $display("FAIL post_reset_rsp got %0d active cycles required 0", seen);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [4:0]  addr;
    logic [31:0] data;
    int          e_lat, e_wr, e_exec, e_init;
    logic        e_err;
    logic [31:0] e_data;
    for (int n = 0; n < 150; n++) begin
      op   = 3'($urandom_range(0, 7));
      addr = 5'($urandom);
      data = $urandom;
      e_lat = 1; e_err = 1'b0; e_data = 32'h0;
      e_wr = 0; e_exec = 0; e_init = 0;
      case (op)
        3'd1: begin
          if (!m_halted) e_lat = DRAIN + 1;
          m_halted = 1'b1;
        end
        3'd2: m_halted = 1'b0;
        3'd3: if (m_halted) begin
          e_lat = 2;
          e_data = (addr == 5'd0) ? 32'h0 : mrf[addr];
        end else e_err = 1'b1;
        3'd4: if (m_halted) begin
          e_lat = 2; e_wr = 1;
          if (addr != 5'd0) mrf[addr] = data;
        end else e_err = 1'b1;
        3'd5: if (m_halted) begin
          e_lat = EXECN + 1; e_exec = EXECN;
        end else e_err = 1'b1;
        3'd6: e_init = 1;
        3'd7: e_err = 1'b1;
        default: e_lat = 1;
      endcase
      send(op, addr, data, $urandom_range(0, 3));
      nvec++;
      if (r_lat != e_lat || r_err !== e_err || r_data !== e_data) begin
        nfail++;
        $display("FAIL rnd_rsp op=%0d got lat=%0d e=%b d=%h required %0d %b %h",
                 op, r_lat, r_err, r_data, e_lat, e_err, e_data);
      end
      nvec++;
      if (r_halted !== m_halted || r_dbghalt !== m_halted) begin
        nfail++;
        $display("FAIL rnd_halt op=%0d got hd=%b h=%b required %b",
                 op, r_halted, r_dbghalt, m_halted);
      end
      nvec++;
      if (n_wr != e_wr || n_exec != e_exec || n_init != e_init) begin
        nfail++;
        $display("FAIL rnd_pulses op=%0d got w=%0d x=%0d i=%0d required %0d %0d %0d",
                 op, n_wr, n_exec, n_init, e_wr, e_exec, e_init);
      end
      nvec++;
      if (n_unstable != 0 || after_valid !== 1'b0 || after_ready !== 1'b1) begin
        nfail++;
        $display("FAIL rnd_hs op=%0d got unstable=%0d v=%b rdy=%b required 0 0 1",
                 op, n_unstable, after_valid, after_ready);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    nRst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_halt();
    test_wr_rd();
    test_exec();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
